// File: rtl/i2c_pkg.sv
// Shared constants for the I2C target: FSM state codes, ACK levels and field widths.
package i2c_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned ADDR_W = 7;
  localparam int unsigned CNT_W  = 3;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_ADDR     = 3'd1;
  localparam logic [2:0] ST_ADDR_ACK = 3'd2;
  localparam logic [2:0] ST_RX       = 3'd3;
  localparam logic [2:0] ST_RX_ACK   = 3'd4;
  localparam logic [2:0] ST_TX       = 3'd5;
  localparam logic [2:0] ST_TX_ACK   = 3'd6;
  localparam logic [2:0] ST_IGNORE   = 3'd7;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

endpackage

// File: rtl/i2c_slave_if.sv
// User-side byte handshake between the I2C target and the logic that consumes/supplies bytes.
interface i2c_slave_if;
  import i2c_pkg::*;

  logic              addressed;
  logic              read_nwrite;
  logic [BYTE_W-1:0] data_o;
  logic              data_available;
  logic              data_request;
  logic [BYTE_W-1:0] data_i;
  logic              data_valid;
  logic              busy;

  modport slave (
    output addressed, read_nwrite, data_o, data_available, data_request, busy,
    input  data_i, data_valid
  );

  modport master (
    input  addressed, read_nwrite, data_o, data_available, data_request, busy,
    output data_i, data_valid
  );

endinterface

// File: rtl/i2c_line_sync.sv
// Two-flop synchronizer with edge detect; edges are gated by i_qual so the SDA instance,
// qualified with synced SCL, yields start (fall) and stop (rise) directly.
module i2c_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic i_line,
  input  logic i_qual,
  output logic o_level,
  output logic o_rise_c,
  output logic o_fall_c
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  // Reset to the idle bus level so release of reset does not fake an edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
      r_prev <= 1'b1;
    end else begin
      r_meta <= i_line;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_level  = r_sync;
  assign o_rise_c = i_qual &  r_sync & ~r_prev;
  assign o_fall_c = i_qual & ~r_sync &  r_prev;

endmodule

// File: rtl/i2c_slave.sv
// I2C target: 7-bit address match, multi-byte write receive and read transmit,
// open-drain SDA, no clock stretching. Bus lines are oversampled on clk.
module i2c_slave
  import i2c_pkg::*;
#(
  parameter logic [ADDR_W-1:0] SLAVE_ADDR = 7'h3A,
  parameter logic [BYTE_W-1:0] IDLE_BYTE  = 8'hFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       SCL,
  inout  wire        SDA,
  i2c_slave_if.slave usr
);

  logic w_scl_s, w_scl_rise, w_scl_fall;
  logic w_sda_s, w_start, w_stop;

  i2c_line_sync u_scl_sync (
    .clk      (clk),
    .rst      (rst),
    .i_line   (SCL),
    .i_qual   (1'b1),
    .o_level  (w_scl_s),
    .o_rise_c (w_scl_rise),
    .o_fall_c (w_scl_fall)
  );

  i2c_line_sync u_sda_sync (
    .clk      (clk),
    .rst      (rst),
    .i_line   (SDA),
    .i_qual   (w_scl_s),
    .o_level  (w_sda_s),
    .o_rise_c (w_stop),
    .o_fall_c (w_start)
  );

  logic [2:0]        r_state,     w_state_nxt;
  logic [CNT_W-1:0]  r_bit_cnt,   w_cnt_nxt;
  logic [BYTE_W-1:0] r_shift,     w_shift_nxt;
  logic              r_bit_seen,  w_seen_nxt;
  logic              r_sda_low,   w_sda_low_nxt;
  logic              r_addressed, w_addressed_nxt;
  logic              r_rnw,       w_rnw_nxt;
  logic [BYTE_W-1:0] r_data_o,    w_data_o_nxt;
  logic              r_avail,     w_avail_nxt;
  logic              r_req,       w_req_nxt;
  logic              r_busy,      w_busy_nxt;
  logic              r_ack,       w_ack_nxt;
  logic [BYTE_W-1:0] w_load;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_bit_seen  <= 1'b0;
      r_sda_low   <= 1'b0;
      r_addressed <= 1'b0;
      r_rnw       <= 1'b0;
      r_data_o    <= '0;
      r_avail     <= 1'b0;
      r_req       <= 1'b0;
      r_busy      <= 1'b0;
      r_ack       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_bit_cnt   <= w_cnt_nxt;
      r_shift     <= w_shift_nxt;
      r_bit_seen  <= w_seen_nxt;
      r_sda_low   <= w_sda_low_nxt;
      r_addressed <= w_addressed_nxt;
      r_rnw       <= w_rnw_nxt;
      r_data_o    <= w_data_o_nxt;
      r_avail     <= w_avail_nxt;
      r_req       <= w_req_nxt;
      r_busy      <= w_busy_nxt;
      r_ack       <= w_ack_nxt;
    end
  end

  // r_bit_seen gates every SCL-fall action so the fall right after a start is not a bit.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_bit_cnt;
    w_shift_nxt     = r_shift;
    w_seen_nxt      = r_bit_seen;
    w_sda_low_nxt   = r_sda_low;
    w_addressed_nxt = r_addressed;
    w_rnw_nxt       = r_rnw;
    w_data_o_nxt    = r_data_o;
    w_avail_nxt     = 1'b0;
    w_req_nxt       = 1'b0;
    w_busy_nxt      = r_busy;
    w_ack_nxt       = r_ack;
    w_load          = usr.data_valid ? usr.data_i : IDLE_BYTE;

    if (w_start) begin
      w_busy_nxt      = 1'b1;
      w_state_nxt     = ST_ADDR;
      w_cnt_nxt       = '0;
      w_seen_nxt      = 1'b0;
      w_sda_low_nxt   = 1'b0;
      w_addressed_nxt = 1'b0;
    end else if (w_stop) begin
      w_busy_nxt      = 1'b0;
      w_state_nxt     = ST_IDLE;
      w_cnt_nxt       = '0;
      w_seen_nxt      = 1'b0;
      w_sda_low_nxt   = 1'b0;
      w_addressed_nxt = 1'b0;
    end else begin
      if (w_scl_rise) w_seen_nxt = 1'b1;
      if (w_scl_fall) w_seen_nxt = 1'b0;

      case (r_state)
        ST_ADDR, ST_RX: begin
          if (w_scl_rise) w_shift_nxt = {r_shift[BYTE_W-2:0], w_sda_s};
          if (w_scl_fall && r_bit_seen) begin
            w_cnt_nxt = r_bit_cnt + CNT_W'(1);
            if (r_bit_cnt == CNT_W'(7)) begin
              if (r_state == ST_RX) begin
                w_data_o_nxt  = r_shift;
                w_avail_nxt   = 1'b1;
                w_state_nxt   = ST_RX_ACK;
                w_sda_low_nxt = 1'b1;
              end else if (r_shift[BYTE_W-1:1] == SLAVE_ADDR && SLAVE_ADDR != '0) begin
                w_state_nxt     = ST_ADDR_ACK;
                w_sda_low_nxt   = 1'b1;
                w_addressed_nxt = 1'b1;
                w_rnw_nxt       = r_shift[0];
                w_req_nxt       = r_shift[0];
              end else begin
                w_state_nxt = ST_IGNORE;
              end
            end
          end
        end

        ST_ADDR_ACK: begin
          if (w_scl_fall && r_bit_seen) begin
            if (r_rnw) begin
              w_state_nxt   = ST_TX;
              w_shift_nxt   = w_load;
              w_sda_low_nxt = ~w_load[BYTE_W-1];
            end else begin
              w_state_nxt   = ST_RX;
              w_sda_low_nxt = 1'b0;
            end
          end
        end

        ST_RX_ACK: begin
          if (w_scl_fall && r_bit_seen) begin
            w_state_nxt   = ST_RX;
            w_sda_low_nxt = 1'b0;
          end
        end

        ST_TX: begin
          if (w_scl_fall && r_bit_seen) begin
            w_cnt_nxt = r_bit_cnt + CNT_W'(1);
            if (r_bit_cnt == CNT_W'(7)) begin
              w_state_nxt   = ST_TX_ACK;
              w_sda_low_nxt = 1'b0;
            end else begin
              w_shift_nxt   = {r_shift[BYTE_W-2:0], 1'b0};
              w_sda_low_nxt = ~r_shift[BYTE_W-2];
            end
          end
        end

        // Request the next byte at the ACK rise; it is loaded half an SCL period later.
        ST_TX_ACK: begin
          if (w_scl_rise) begin
            w_ack_nxt = w_sda_s;
            w_req_nxt = (w_sda_s == I2C_ACK);
          end
          if (w_scl_fall && r_bit_seen) begin
            if (r_ack == I2C_NACK) begin
              w_state_nxt   = ST_IGNORE;
              w_sda_low_nxt = 1'b0;
            end else begin
              w_state_nxt   = ST_TX;
              w_shift_nxt   = w_load;
              w_sda_low_nxt = ~w_load[BYTE_W-1];
            end
          end
        end

        ST_IGNORE: w_sda_low_nxt = 1'b0;

        default: begin
          w_state_nxt = r_state;
        end
      endcase
    end
  end

  assign SDA = r_sda_low ? 1'b0 : 1'bz;

  assign usr.addressed      = r_addressed;
  assign usr.read_nwrite    = r_rnw;
  assign usr.data_o         = r_data_o;
  assign usr.data_available = r_avail;
  assign usr.data_request   = r_req;
  assign usr.busy           = r_busy;

endmodule
